stream_downsize: RTL and testbench
==================================

Name: stream_downsize

Overview:
Valid/ready stream width down-converter: accepts one wide word per upstream handshake and emits it as RATIO narrow beats, least-significant slice first.
Counterpart of the stream upsizer; sits between a wide producer and a narrow consumer, typically feeding or fed by the team's FIFO stream wrapper.
Supports partial words via a slice-count sideband and marks the final slice of each word with down_last.

Parameters:
OUT_WIDTH, 8, width of one output beat in bits.
RATIO, 4, number of output slices per input word (>=1); input width IN_WIDTH = OUT_WIDTH*RATIO.

Ports:
clk_i  input  1  clock; all state on rising edge.
rst_i  input  1  reset, asynchronous, active-low (asserted when 0).
up_valid  input  1  upstream word valid.
up_data  input  IN_WIDTH  upstream word; slice k = bits [k*OUT_WIDTH +: OUT_WIDTH].
up_len_m1  input  CW  number of valid slices minus 1 (0..RATIO-1); CW = max(1, $clog2(RATIO)).
up_ready  output  1  block can accept a word this cycle.
down_valid  output  1  output beat valid.
down_data  output  OUT_WIDTH  current slice.
down_last  output  1  current slice is last valid slice of its word.
down_ready  input  1  downstream accepts beat.

Behaviour:
- State: valid_q (word held), data_q [IN_WIDTH], len_q [CW], cnt_q [CW].
- Reset (rst_i=0, async): valid_q=0, cnt_q=0, len_q=0, data_q=0 -> down_valid=0, down_last=0, down_data=0, up_ready=1.
- down_valid = valid_q; down_data = data_q slice cnt_q; down_last = valid_q && (cnt_q == len_q).
- up_ready = !valid_q || (down_ready && down_last) (combinational; no bubble between words).
- push = up_valid && up_ready; pop = down_valid && down_ready.
- push: data_q<=up_data, len_q<=up_len_m1, cnt_q<=0, valid_q<=1 (takes priority over pop-of-last in same cycle).
- pop && !down_last: cnt_q<=cnt_q+1.
- pop && down_last && !push: valid_q<=0, cnt_q<=0.
- Latency: first slice presented the cycle after the push handshake. Throughput: len+1 beats per word, 1 beat/cycle sustained under continuous ready.
- Stall: while down_valid && !down_ready, down_data/down_last held stable; no slice skipped or repeated.
- up_data/up_len_m1 sampled only on push; ignored otherwise. Slices above len_q never emitted.
- up_len_m1 > RATIO-1 (only possible when RATIO is not a power of two): treated as RATIO-1.
- RATIO=1: degenerates to a one-entry pipeline register, down_last always 1 when valid.
- Reset mid-word: outstanding slices discarded; after release the next push starts at slice 0.

Decomposition:
- Package stream_downsize_pkg: count-width helper function (max(1,clog2)) and the clamp rule for up_len_m1; no typedefs beyond a slice-index type.
- Single module; no sub-module needed. Bench composes it with the FIFO stream wrapper downstream for backpressure tests.

Test Plan:
1. Hold rst_i=0 -> down_valid=0, down_last=0, up_ready=1; release, no stimulus -> outputs unchanged.
2. Push 0xDDCCBBAA, up_len_m1=3, down_ready=1 -> beats AA,BB,CC,DD on cycles 1-4, down_last only on DD, up_ready=0 cycles 1-3, 1 on cycle 4.
3. up_valid held, words 0x03020100 then 0x07060504 (len 3), down_ready=1 -> 8 contiguous beats 00..07, no idle cycle, down_last on 03 and 07.
4. Push 0xFFEE2211, up_len_m1=1 -> beats 11, 22 (down_last on 22); EE/FF never appear; up_ready=1 on the 22 cycle.
5. down_ready pattern 1,0,0,1,0,1,1 on word 0x44332211 -> output sequence exactly 11,22,33,44, down_data stable across every stalled cycle.
6. Push word, pop 2 slices, pulse rst_i=0 mid-cycle -> down_valid drops immediately; after release push 0x0D0C0B0A -> first beat 0A.

Source files
------------

// File: rtl/stream_downsize_pkg.sv
// stream_downsize_pkg: shared sizing and length-clamp helpers for the stream down-converter.
package stream_downsize_pkg;

    function automatic int cnt_width(input int ratio);
        return (ratio > 1) ? $clog2(ratio) : 1;
    endfunction

    // A slice count beyond the last physical slice saturates to that last slice.
    function automatic int clamp_len(input int len_m1, input int ratio);
        return (len_m1 > ratio - 1) ? ratio - 1 : len_m1;
    endfunction

endpackage

// File: rtl/stream_downsize.sv
// stream_downsize: valid/ready width down-converter emitting one wide word as
// up to RATIO narrow beats, least-significant slice first, last slice flagged.
module stream_downsize
    import stream_downsize_pkg::*;
#(
    parameter int OUT_WIDTH = 8,
    parameter int RATIO     = 4,
    localparam int IN_WIDTH = OUT_WIDTH * RATIO,
    localparam int CW       = cnt_width(RATIO)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 up_valid,
    input  logic [IN_WIDTH-1:0]  up_data,
    input  logic [CW-1:0]        up_len_m1,
    output logic                 up_ready,
    output logic                 down_valid,
    output logic [OUT_WIDTH-1:0] down_data,
    output logic                 down_last,
    input  logic                 down_ready
);

    logic                valid_q, valid_d;
    logic [IN_WIDTH-1:0] data_q, data_d;
    logic [CW-1:0]       len_q, len_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                push, pop;
    logic [CW-1:0]       len_in;

    assign len_in     = CW'(clamp_len(32'(up_len_m1), RATIO));
    assign down_valid = valid_q;
    assign down_data  = data_q[cnt_q*OUT_WIDTH +: OUT_WIDTH];
    assign down_last  = valid_q && (cnt_q == len_q);
    // Accepting while the last beat leaves lets back-to-back words stream without a bubble.
    assign up_ready   = !valid_q || (down_ready && down_last);
    assign push       = up_valid && up_ready;
    assign pop        = down_valid && down_ready;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        if (push) begin
            valid_d = 1'b1;
            data_d  = up_data;
            len_d   = len_in;
            cnt_d   = '0;
        end else if (pop) begin
            valid_d = !down_last;
            cnt_d   = down_last ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_stream_downsize.sv
// tb_stream_downsize: table-driven per-cycle vectors plus hand sequences for
// mid-word reset and length clamping on a RATIO=3 instance.
module tb_stream_downsize;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        up_valid = 1'b0;
    logic [31:0] up_data = '0;
    logic [1:0]  up_len_m1 = '0;
    logic        up_ready;
    logic        down_valid;
    logic [7:0]  down_data;
    logic        down_last;
    logic        down_ready = 1'b1;

    logic        r3_up_valid = 1'b0;
    logic [23:0] r3_up_data = '0;
    logic [1:0]  r3_up_len_m1 = '0;
    logic        r3_up_ready;
    logic        r3_down_valid;
    logic [7:0]  r3_down_data;
    logic        r3_down_last;

    int checks = 0;
    int failures = 0;

    always #5 clk_i = ~clk_i;

    stream_downsize #(.OUT_WIDTH(8), .RATIO(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .up_valid(up_valid), .up_data(up_data), .up_len_m1(up_len_m1), .up_ready(up_ready),
        .down_valid(down_valid), .down_data(down_data), .down_last(down_last), .down_ready(down_ready)
    );

    stream_downsize #(.OUT_WIDTH(8), .RATIO(3)) dut3 (
        .clk_i(clk_i), .rst_i(rst_i),
        .up_valid(r3_up_valid), .up_data(r3_up_data), .up_len_m1(r3_up_len_m1), .up_ready(r3_up_ready),
        .down_valid(r3_down_valid), .down_data(r3_down_data), .down_last(r3_down_last), .down_ready(1'b1)
    );

    typedef struct {
        string       name;
        logic        uv;
        logic [31:0] ud;
        logic [1:0]  ul;
        logic        dr;
        logic        ev;
        logic [7:0]  ed;
        logic        el;
        logic        eu;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(string n, logic uv, logic [31:0] ud, logic [1:0] ul, logic dr,
                                logic ev, logic [7:0] ed, logic el, logic eu);
        vec_t v;
        v.name = n; v.uv = uv; v.ud = ud; v.ul = ul; v.dr = dr;
        v.ev = ev; v.ed = ed; v.el = el; v.eu = eu;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic ev, input logic [7:0] ed, input logic el, input logic eu);
        chk({tag, ".down_valid"}, 32'(down_valid), 32'(ev));
        chk({tag, ".down_last"}, 32'(down_last), 32'(el));
        chk({tag, ".up_ready"}, 32'(up_ready), 32'(eu));
        if (ev) chk({tag, ".down_data"}, 32'(down_data), 32'(ed));
    endtask

    initial begin
        // 1: reset state and quiet idle after release
        repeat (2) @(negedge clk_i);
        #1 chk_out("rst", 1'b0, 8'h00, 1'b0, 1'b1);
        chk("rst.down_data", 32'(down_data), 32'h0);
        @(negedge clk_i) rst_i = 1'b1;
        repeat (2) begin
            @(negedge clk_i);
            #1 chk_out("idle", 1'b0, 8'h00, 1'b0, 1'b1);
        end

        // 2: single full word
        vecs.push_back(mk("t2c0", 1, 32'hDDCCBBAA, 3, 1, 0, 8'h00, 0, 1));
        vecs.push_back(mk("t2c1", 0, 32'h0, 0, 1, 1, 8'hAA, 0, 0));
        vecs.push_back(mk("t2c2", 0, 32'h0, 0, 1, 1, 8'hBB, 0, 0));
        vecs.push_back(mk("t2c3", 0, 32'h0, 0, 1, 1, 8'hCC, 0, 0));
        vecs.push_back(mk("t2c4", 0, 32'h0, 0, 1, 1, 8'hDD, 1, 1));
        vecs.push_back(mk("t2c5", 0, 32'h0, 0, 1, 0, 8'h00, 0, 1));
        // 3: back-to-back words with no bubble
        vecs.push_back(mk("t3c0", 1, 32'h03020100, 3, 1, 0, 8'h00, 0, 1));
        vecs.push_back(mk("t3c1", 1, 32'h07060504, 3, 1, 1, 8'h00, 0, 0));
        vecs.push_back(mk("t3c2", 1, 32'h07060504, 3, 1, 1, 8'h01, 0, 0));
        vecs.push_back(mk("t3c3", 1, 32'h07060504, 3, 1, 1, 8'h02, 0, 0));
        vecs.push_back(mk("t3c4", 1, 32'h07060504, 3, 1, 1, 8'h03, 1, 1));
        vecs.push_back(mk("t3c5", 0, 32'h0, 0, 1, 1, 8'h04, 0, 0));
        vecs.push_back(mk("t3c6", 0, 32'h0, 0, 1, 1, 8'h05, 0, 0));
        vecs.push_back(mk("t3c7", 0, 32'h0, 0, 1, 1, 8'h06, 0, 0));
        vecs.push_back(mk("t3c8", 0, 32'h0, 0, 1, 1, 8'h07, 1, 1));
        vecs.push_back(mk("t3c9", 0, 32'h0, 0, 1, 0, 8'h00, 0, 1));
        // 4: partial word of two slices
        vecs.push_back(mk("t4c0", 1, 32'hFFEE2211, 1, 1, 0, 8'h00, 0, 1));
        vecs.push_back(mk("t4c1", 0, 32'h0, 0, 1, 1, 8'h11, 0, 0));
        vecs.push_back(mk("t4c2", 0, 32'h0, 0, 1, 1, 8'h22, 1, 1));
        vecs.push_back(mk("t4c3", 0, 32'h0, 0, 1, 0, 8'h00, 0, 1));
        // 5: backpressure 1,0,0,1,0,1,1; junk offered while stalled must be ignored
        vecs.push_back(mk("t5c0", 1, 32'h44332211, 3, 1, 0, 8'h00, 0, 1));
        vecs.push_back(mk("t5c1", 0, 32'h0, 0, 1, 1, 8'h11, 0, 0));
        vecs.push_back(mk("t5c2", 1, 32'hDEADBEEF, 0, 0, 1, 8'h22, 0, 0));
        vecs.push_back(mk("t5c3", 1, 32'hDEADBEEF, 0, 0, 1, 8'h22, 0, 0));
        vecs.push_back(mk("t5c4", 0, 32'h0, 0, 1, 1, 8'h22, 0, 0));
        vecs.push_back(mk("t5c5", 0, 32'h0, 0, 0, 1, 8'h33, 0, 0));
        vecs.push_back(mk("t5c6", 0, 32'h0, 0, 1, 1, 8'h33, 0, 0));
        vecs.push_back(mk("t5c7", 0, 32'h0, 0, 1, 1, 8'h44, 1, 1));
        vecs.push_back(mk("t5c8", 0, 32'h0, 0, 1, 0, 8'h00, 0, 1));

        foreach (vecs[i]) begin
            @(negedge clk_i);
            up_valid = vecs[i].uv; up_data = vecs[i].ud; up_len_m1 = vecs[i].ul; down_ready = vecs[i].dr;
            #1 chk_out(vecs[i].name, vecs[i].ev, vecs[i].ed, vecs[i].el, vecs[i].eu);
        end

        // 6: reset mid-word discards remaining slices
        @(negedge clk_i);
        up_valid = 1; up_data = 32'h87654321; up_len_m1 = 3; down_ready = 1;
        @(negedge clk_i) up_valid = 0;
        #1 chk_out("t6s0", 1, 8'h21, 0, 0);
        @(negedge clk_i);
        #1 chk_out("t6s1", 1, 8'h43, 0, 0);
        @(negedge clk_i) down_ready = 0;
        #1 chk_out("t6s2", 1, 8'h65, 0, 0);
        #2 rst_i = 0;
        #1 chk_out("t6rst", 0, 8'h00, 0, 1);
        @(negedge clk_i);
        rst_i = 1; down_ready = 1; up_valid = 1; up_data = 32'h0D0C0B0A; up_len_m1 = 3;
        @(negedge clk_i) up_valid = 0;
        #1 chk_out("t6n0", 1, 8'h0A, 0, 0);
        @(negedge clk_i);
        #1 chk_out("t6n1", 1, 8'h0B, 0, 0);
        repeat (3) @(negedge clk_i);

        // RATIO=3: len 3 clamps to the third slice
        r3_up_valid = 1; r3_up_data = 24'hCCBBAA; r3_up_len_m1 = 3;
        @(negedge clk_i) r3_up_valid = 0;
        #1 chk("r3s0.data", 32'(r3_down_data), 32'hAA);
        chk("r3s0.last", 32'(r3_down_last), 32'h0);
        @(negedge clk_i);
        #1 chk("r3s1.data", 32'(r3_down_data), 32'hBB);
        chk("r3s1.last", 32'(r3_down_last), 32'h0);
        @(negedge clk_i);
        #1 chk("r3s2.data", 32'(r3_down_data), 32'hCC);
        chk("r3s2.last", 32'(r3_down_last), 32'h1);
        chk("r3s2.up_ready", 32'(r3_up_ready), 32'h1);
        @(negedge clk_i);
        #1 chk("r3end.valid", 32'(r3_down_valid), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
